// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with its own oversampling tick generator.
// RxD is brought into the clock domain through a two-flop synchronizer.
// The start bit is validated at its midpoint, and each data bit and the
// stop bit are sampled at their midpoints. A good frame gives a
// one-clock rx_valid strobe; a stop bit sampled low gives a one-clock
// rx_error strobe.
module uart_rx #(
    parameter int TICK_DIV  = 651,  // clk cycles per oversampling tick
    parameter int OSR       = 16,   // oversampling ticks per bit (even, >= 4)
    parameter int DATA_BITS = 8     // data bits per frame, LSB first
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_error,
    output logic                 rx_busy
);

    localparam int TICK_W = $clog2(OSR);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [TICK_W-1:0] MID_START = TICK_W'(OSR / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OSR - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic [15:0]          div_cnt;
    logic                 tick;
    logic                 rxd_m;
    logic                 rxd_s;
    logic [2:0]           state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    // Free-running divider. tick is high for one clk each time it wraps to zero.
    // NOTE: all sequential state uses non-blocking (<=) assignments so every
    // flop samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (reset)
            div_cnt <= '0;
        else if (div_cnt == 16'(TICK_DIV - 1))
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 16'd1;
    end

    assign tick = (div_cnt == '0);

    // Two-flop synchronizer for the asynchronous line. It resets to the idle
    // level so that reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= RxD;
            rxd_s <= rxd_m;
        end
    end

    // Frame FSM. It moves only on ticks; the strobes are cleared on every
    // other clock, so each strobe lasts exactly one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_error  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rxd_s) begin
                            state    <= S_START;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                    S_START: begin
                        if (tick_cnt == MID_START) begin
                            tick_cnt <= '0;
                            // A line that is high again at mid start bit was a glitch.
                            state    <= rxd_s ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT)
                                state <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            // The FSM leaves at mid stop bit so that a start bit
                            // directly after the stop bit is still caught.
                            if (rxd_s) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                rx_error <= 1'b1;
                                state    <= S_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_BREAK: begin
                        // A line held low stays here, so it cannot be taken
                        // as a string of new start bits.
                        if (rxd_s)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_busy = (state == S_START) || (state == S_DATA) || (state == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. It uses a short tick divider so that the whole
// run stays small. Expected strobes go into a queue when a frame is
// driven, and a monitor takes them out and compares them when the DUT
// strobes.
module tb_uart_rx;

    localparam int TICK_DIV = 6;
    localparam int OSR      = 16;
    localparam int BIT_CLK  = TICK_DIV * OSR;         // 96 clk per bit
    localparam int NOM_LAT  = (2 * 9 + 1) * BIT_CLK / 2; // 9.5 bits

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       rx_busy;

    uart_rx #(.TICK_DIV(TICK_DIV), .OSR(OSR), .DATA_BITS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .RxD      (RxD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        int         bit_clk;
        int         gap_clk;
        logic       stop_bit;
        logic       exp_valid;
    } vec_t;

    exp_t       exp_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    int         start_cyc;
    int         valid_cyc = -1;
    logic       prev_strobe = 1'b0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic ok);
        exp_t e;
        if (ok) begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.is_err  = 1'b1;
            e.data    = last_good;
        end
        exp_q.push_back(e);
    endtask

    task automatic hold_line(input logic v, input int n);
        RxD = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame. The bench can check rx_busy at the middle of data
    // bit 4, or pulse reset there for one clk.
    task automatic send_frame(input logic [7:0] d, input int bit_clk, input logic stop_val,
                              input bit chk_busy, input bit rst_mid);
        start_cyc = cyc;
        hold_line(1'b0, bit_clk);
        for (int b = 0; b < 8; b++) begin
            RxD = d[b];
            for (int c = 0; c < bit_clk; c++) begin
                if (b == 4 && c == bit_clk / 2) begin
                    if (chk_busy)
                        check("busy_mid_frame", rx_busy, 1);
                    if (rst_mid) begin
                        reset = 1'b1;
                        @(negedge clk);
                        reset = 1'b0;
                        check("rst_rx_data", rx_data, 0);
                        check("rst_rx_valid", rx_valid, 0);
                        check("rst_rx_error", rx_error, 0);
                        check("rst_rx_busy", rx_busy, 0);
                        last_good = 8'h00;
                    end
                end
                @(negedge clk);
            end
        end
        hold_line(stop_val, bit_clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (rx_valid || rx_error) begin
            check("strobe_exclusive", rx_valid & rx_error, 0);
            check("strobe_one_clk", prev_strobe, 0);
            if (rx_valid)
                valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {rx_valid, rx_error}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind_err", rx_error, e.is_err);
                check("rx_data", rx_data, e.data);
            end
        end
        prev_strobe = rx_valid | rx_error;
    end

    vec_t vecs[5];

    initial begin
        vecs[0] = '{data: 8'h00, bit_clk: BIT_CLK,     gap_clk: BIT_CLK, stop_bit: 1'b1, exp_valid: 1'b1};
        vecs[1] = '{data: 8'hFF, bit_clk: BIT_CLK,     gap_clk: 0,       stop_bit: 1'b1, exp_valid: 1'b1};
        vecs[2] = '{data: 8'h3C, bit_clk: BIT_CLK,     gap_clk: 0,       stop_bit: 1'b1, exp_valid: 1'b1};
        vecs[3] = '{data: 8'hC3, bit_clk: BIT_CLK - 2, gap_clk: BIT_CLK, stop_bit: 1'b1, exp_valid: 1'b1};
        vecs[4] = '{data: 8'hC3, bit_clk: BIT_CLK + 2, gap_clk: BIT_CLK, stop_bit: 1'b1, exp_valid: 1'b1};

        RxD   = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_error", rx_error, 0);
        check("reset_rx_busy", rx_busy, 0);
        hold_line(1'b1, BIT_CLK);

        // A single nominal frame: data, busy during the frame, and latency.
        expect_frame(8'hA5, 1'b1);
        send_frame(8'hA5, BIT_CLK, 1'b1, 1'b1, 1'b0);
        hold_line(1'b1, BIT_CLK);
        check("busy_after_frame", rx_busy, 0);
        check("latency_in_window",
              (valid_cyc - start_cyc >= NOM_LAT - TICK_DIV - 3) &&
              (valid_cyc - start_cyc <= NOM_LAT + TICK_DIV + 3), 1);

        // Table: back-to-back frames, then frames at the rate tolerance limits.
        foreach (vecs[i]) begin
            if (vecs[i].gap_clk > 0)
                hold_line(1'b1, vecs[i].gap_clk);
            expect_frame(vecs[i].data, vecs[i].exp_valid);
            send_frame(vecs[i].data, vecs[i].bit_clk, vecs[i].stop_bit, 1'b0, 1'b0);
        end
        hold_line(1'b1, BIT_CLK);
        check("table_drained", exp_q.size(), 0);

        // Glitch: a short low pulse must be rejected at mid start bit.
        hold_line(1'b0, 3 * TICK_DIV);
        hold_line(1'b1, 12);
        check("glitch_busy_high", rx_busy, 1);
        hold_line(1'b1, 8 * TICK_DIV + 20);
        check("glitch_busy_low", rx_busy, 0);
        hold_line(1'b1, BIT_CLK);
        expect_frame(8'h55, 1'b1);
        send_frame(8'h55, BIT_CLK, 1'b1, 1'b0, 1'b0);
        hold_line(1'b1, BIT_CLK);

        // Framing error followed by a long break, then a clean frame.
        expect_frame(8'h81, 1'b0);
        send_frame(8'h81, BIT_CLK, 1'b0, 1'b0, 1'b0);
        hold_line(1'b0, BIT_CLK);
        check("break_busy_low", rx_busy, 0);
        hold_line(1'b0, 2 * BIT_CLK);
        check("break_no_new_frame", exp_q.size(), 0);
        hold_line(1'b1, BIT_CLK);
        expect_frame(8'h42, 1'b1);
        send_frame(8'h42, BIT_CLK, 1'b1, 1'b0, 1'b0);
        hold_line(1'b1, BIT_CLK);

        // Reset during data bit 4 aborts the frame without a strobe.
        send_frame(8'hF0, BIT_CLK, 1'b1, 1'b0, 1'b1);
        hold_line(1'b1, 2 * BIT_CLK);
        expect_frame(8'h0F, 1'b1);
        send_frame(8'h0F, BIT_CLK, 1'b1, 1'b0, 1'b0);
        hold_line(1'b1, 2 * BIT_CLK);
        check("final_rx_data", rx_data, 8'h0F);
        check("all_expected_seen", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
